// File: rtl/ats21_pkg.sv
// ats21 shared types: opcodes, status codes, FSM states, widths.
// Used by ats21 and ats21_mul (ATS21_FAST_MUL_EN selects the multiplier).
package ats21_pkg;

  localparam int OPW = 12;
  localparam int DW  = 24;

  localparam logic [DW-1:0] SAT_VAL = 24'hFFFFFF;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_MAC = 4'd3,
    OP_CLR = 4'd4
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_OK   = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/ats21_mul.sv
// 12x12 unsigned multiplier with start/done handshake.
// Shift-add over 12 cycles, or one cycle with ATS21_FAST_MUL_EN.
module ats21_mul
  import ats21_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [OPW-1:0] a_i,
  input  logic [OPW-1:0] b_i,
  output logic           done_o,
  output logic [DW-1:0]  prod_o
);

`ifdef ATS21_FAST_MUL_EN
  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  logic           busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= start_i;
      if (start_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
    end
  end

  assign done_o = busy_q;
  assign prod_o = {12'b0, a_q} * {12'b0, b_q};
`else
  logic [DW-1:0]  a_q;
  logic [OPW-1:0] b_q;
  logic [DW-1:0]  p_q;
  logic [DW-1:0]  p_d;
  logic [3:0]     cnt_q;

  assign p_d = p_q + (b_q[0] ? a_q : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      a_q   <= {12'b0, a_i};
      b_q   <= b_i;
      p_q   <= '0;
      cnt_q <= 4'd12;
    end else if (cnt_q != 4'd0) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      p_q   <= p_d;
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // last step's sum is handed out directly so the caller can latch it
  assign done_o = (cnt_q == 4'd1);
  assign prod_o = p_d;
`endif

endmodule

// File: rtl/ats21.sv
// ats21 arithmetic transaction unit: ADD/SUB/MUL/MAC/CLR with accumulator.
// ATS21_FAST_MUL_EN (in ats21_mul) makes MUL/MAC single-cycle.
module ats21
  import ats21_pkg::*;
#(
  parameter bit ACC_SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [15:0]   ctrlA,
  input  logic [15:0]   ctrlB,
  output logic          ready,
  output logic [1:0]    stat,
  output logic [DW-1:0] data
);

  state_e         state_q;
  logic [3:0]     op_q;
  logic [OPW-1:0] a_q;
  logic [15:0]    b_q;
  logic [DW-1:0]  acc_q;
  logic [DW-1:0]  acc_d;
  logic [DW-1:0]  data_q;
  logic [1:0]     stat_q;
  logic           ready_q;

  logic           mul_start;
  logic           mul_done;
  logic [DW-1:0]  prod;
  logic [DW:0]    sum;
  logic [DW-1:0]  res;
  logic           err;
  logic           exec_done;

  assign mul_start = (state_q == S_IDLE) && req
                   && is_mul(ctrlA[15:12]);

  ats21_mul u_mul (
    .clk     (clk),
    .reset   (reset),
    .start_i (mul_start),
    .a_i     (ctrlA[11:0]),
    .b_i     (ctrlB[11:0]),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  always_comb begin
    res   = '0;
    acc_d = acc_q;
    err   = 1'b0;
    sum   = {1'b0, acc_q} + {1'b0, prod};
    case (op_q)
      OP_ADD: res = {12'b0, a_q} + {8'b0, b_q};
      OP_SUB: res = {12'b0, a_q} - {8'b0, b_q};
      OP_MUL: res = prod;
      OP_MAC: begin
        res   = (sum[DW] && ACC_SATURATE) ? SAT_VAL
                                          : sum[DW-1:0];
        acc_d = res;
      end
      OP_CLR: acc_d = '0;
      default: err = 1'b1;
    endcase
  end

  assign exec_done = is_mul(op_q) ? mul_done : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      stat_q  <= ST_IDLE;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          op_q    <= ctrlA[15:12];
          a_q     <= ctrlA[11:0];
          b_q     <= ctrlB;
          ready_q <= 1'b0;
          stat_q  <= ST_BUSY;
          state_q <= S_EXEC;
        end
        S_EXEC: if (exec_done) begin
          data_q  <= res;
          acc_q   <= acc_d;
          stat_q  <= err ? ST_ERR : ST_OK;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          stat_q  <= ST_IDLE;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          stat_q  <= ST_IDLE;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign stat  = stat_q;
  assign data  = data_q;

endmodule

// File: tb/tb_ats21.sv
// Self-checking bench for ats21: saturating and wrapping instances.
// Directed plan steps followed by randomized ops against a reference model.
module tb_ats21;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [15:0] ctrlA = '0;
  logic [15:0] ctrlB = '0;
  logic        ready, ready_w;
  logic [1:0]  stat, stat_w;
  logic [23:0] data, data_w;

  int vec = 0;
  int err = 0;

`ifdef ATS21_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 12;
`endif

  longint acc_s = 0;
  longint acc_w = 0;
  logic [23:0] exp_d = '0;
  logic [23:0] exp_dw = '0;
  bit exp_err = 0;
  int exp_lat = 1;

  always #5 clk = ~clk;

  ats21 #(.ACC_SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .req(req),
    .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready), .stat(stat), .data(data)
  );

  ats21 #(.ACC_SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .req(req),
    .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready_w), .stat(stat_w), .data(data_w)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model(input int op, input int a, input int b);
    longint m;
    longint t;
    m = longint'(a) * longint'(b & 12'hFFF);
    exp_err = 0;
    exp_lat = 1;
    case (op)
      0: begin exp_d = 24'(a + b); exp_dw = exp_d; end
      1: begin
        t = (longint'(a) - longint'(b)) & 64'hFFFFFF;
        exp_d = 24'(t); exp_dw = exp_d;
      end
      2: begin exp_d = 24'(m); exp_dw = exp_d; exp_lat = MUL_LAT; end
      3: begin
        t = acc_s + m;
        acc_s = (t > 64'hFFFFFF) ? 64'hFFFFFF : t;
        acc_w = (acc_w + m) % 64'h1000000;
        exp_d = 24'(acc_s); exp_dw = 24'(acc_w);
        exp_lat = MUL_LAT;
      end
      4: begin acc_s = 0; acc_w = 0; exp_d = 0; exp_dw = 0; end
      default: begin exp_d = 0; exp_dw = 0; exp_err = 1; end
    endcase
  endtask

  task automatic run_op(input int op, input int a, input int b,
                        input bit poke);
    int busy;
    model(op, a, b);
    @(negedge clk);
    chk("ready_pre", {31'b0, ready}, 32'd1);
    ctrlA = {4'(op), 12'(a)};
    ctrlB = 16'(b);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    ctrlA = 16'($urandom);
    ctrlB = 16'($urandom);
    busy = 0;
    @(negedge clk);
    while (stat == 2'b01 && busy < 40) begin
      busy++;
      req = (poke && busy == 3);
      @(negedge clk);
    end
    req = 1'b0;
    chk("busy_cycles", busy, exp_lat);
    chk("done_stat", {30'b0, stat}, exp_err ? 32'd3 : 32'd2);
    chk("done_ready", {31'b0, ready}, 32'd0);
    chk("done_data", {8'b0, data}, {8'b0, exp_d});
    chk("done_data_wrap", {8'b0, data_w}, {8'b0, exp_dw});
    chk("done_stat_wrap", {30'b0, stat_w}, {30'b0, stat});
    @(negedge clk);
    chk("idle_stat", {30'b0, stat}, 32'd0);
    chk("idle_ready", {31'b0, ready}, 32'd1);
    chk("idle_data", {8'b0, data}, {8'b0, exp_d});
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_stat", {30'b0, stat}, 32'd0);
    chk("rst_data", {8'b0, data}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_stat", {30'b0, stat}, 32'd0);
    chk("rel_ready", {31'b0, ready}, 32'd1);

    run_op(0, 12'h123, 16'h1000, 0);
    run_op(1, 12'h001, 16'h0002, 0);
    run_op(1, 12'h0FF, 16'h000F, 0);
    run_op(2, 12'hFFF, 16'h0FFF, 1);
    @(negedge clk);
    chk("no_queue_stat", {30'b0, stat}, 32'd0);
    chk("no_queue_data", {8'b0, data}, {8'b0, exp_d});

    run_op(4, 0, 0, 0);
    run_op(3, 12'hFFF, 16'h0FFF, 0);
    run_op(3, 12'hFFF, 16'h0FFF, 0);
    run_op(7, 0, 0, 0);
    run_op(3, 0, 0, 0);
    run_op(15, 12'hABC, 16'h1234, 0);

    // abort a MUL on its 5th busy cycle
    @(negedge clk);
    ctrlA = 16'h2ABC;
    ctrlB = 16'h0123;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy", {30'b0, stat}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_stat", {30'b0, stat}, 32'd0);
    chk("abort_data", {8'b0, data}, 32'd0);
    acc_s = 0;
    acc_w = 0;
    exp_d = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("post_abort_stat", {30'b0, stat}, 32'd0);
    end
    chk("post_abort_data", {8'b0, data}, 32'd0);
    run_op(3, 12'h002, 16'h0003, 0);

    for (int i = 0; i < 40; i++) begin
      int op;
      op = (i % 9 == 8) ? 15 : int'($urandom_range(0, 6));
      run_op(op, int'($urandom_range(0, 4095)),
             int'($urandom_range(0, 65535)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
